// File: rtl/psychic5_video_core.sv
// Psychic 5 video core: 6 MHz enable generation, 384x264 raster timing,
// FG/BG tile attribute lookup with scroll and flip, palette lookup, CPU port.
module psychic5_video_core (
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_RST,
  input  logic        i_EMU_CLK12MPCEN_n,
  output logic        o_EMU_CLK6MPCEN_n,
  output logic        o_EMU_CLK6MNCEN_n,
  input  logic [12:0] i_CPU_ADDR,
  input  logic [7:0]  i_CPU_DOUT,
  output logic [7:0]  o_CPU_DIN,
  input  logic        i_CPU_RD_n,
  input  logic        i_CPU_WR_n,
  input  logic        i_TM_BG_ATTR_CS_n,
  input  logic        i_TM_FG_ATTR_CS_n,
  input  logic        i_TM_BG_SCR_CS_n,
  input  logic        i_TM_PALETTE_CS_n,
  input  logic        i_FLIP,
  output logic        o_CSYNC,
  output logic [3:0]  o_VIDEO_R,
  output logic [3:0]  o_VIDEO_G,
  output logic [3:0]  o_VIDEO_B,
  output logic [8:0]  __REF_HCOUNTER,
  output logic [8:0]  __REF_VCOUNTER
);
  localparam int STAGES = 2;
  localparam logic [8:0] H_LAST = 9'd383;
  localparam logic [8:0] V_LAST = 9'd263;

  typedef struct packed {
    logic [8:0] h;
    logic [8:0] v;
    logic       act;
  } pix_t;

  logic clk, rst;
  assign clk = i_EMU_MCLK;
  assign rst = i_EMU_RST;

  // 6M enables: registered so each is low for exactly one MCLK per phase edge
  logic phase, pix_tick;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase             <= 1'b0;
      o_EMU_CLK6MPCEN_n <= 1'b1;
      o_EMU_CLK6MNCEN_n <= 1'b1;
    end else begin
      o_EMU_CLK6MPCEN_n <= ~(~i_EMU_CLK12MPCEN_n & ~phase);
      o_EMU_CLK6MNCEN_n <= ~(~i_EMU_CLK12MPCEN_n &  phase);
      if (!i_EMU_CLK12MPCEN_n) phase <= ~phase;
    end
  end
  assign pix_tick = ~o_EMU_CLK6MPCEN_n;

  logic [8:0] h, v;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (pix_tick) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? 9'd0 : v + 9'd1;
      end else begin
        h <= h + 9'd1;
      end
    end
  end

  // CPU side
  logic [3:0] cs;
  logic       one_cs;
  logic [9:0] cpu_a;
  logic [7:0] bg_ram  [1024];
  logic [7:0] fg_ram  [1024];
  logic [7:0] pal_ram [1024];
  logic [7:0] scr_reg [4];

  assign cs     = {~i_TM_PALETTE_CS_n, ~i_TM_BG_SCR_CS_n, ~i_TM_FG_ATTR_CS_n, ~i_TM_BG_ATTR_CS_n};
  assign one_cs = $onehot(cs);
  assign cpu_a  = i_CPU_ADDR[9:0];

  always_ff @(posedge clk) begin
    if (!i_CPU_WR_n && one_cs) begin
      if (cs[0]) bg_ram[cpu_a]  <= i_CPU_DOUT;
      if (cs[1]) fg_ram[cpu_a]  <= i_CPU_DOUT;
      if (cs[3]) pal_ram[cpu_a] <= i_CPU_DOUT;
    end
  end

  // Scroll bytes kept whole so readback returns exactly what was written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) scr_reg[i] <= '0;
    end else if (!i_CPU_WR_n && one_cs && cs[2]) begin
      scr_reg[i_CPU_ADDR[1:0]] <= i_CPU_DOUT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_CPU_DIN <= 8'hFF;
    end else if (!i_CPU_RD_n && one_cs) begin
      if (cs[0])      o_CPU_DIN <= bg_ram[cpu_a];
      else if (cs[1]) o_CPU_DIN <= fg_ram[cpu_a];
      else if (cs[2]) o_CPU_DIN <= scr_reg[i_CPU_ADDR[1:0]];
      else            o_CPU_DIN <= pal_ram[cpu_a];
    end else begin
      o_CPU_DIN <= 8'hFF;
    end
  end

  // Stage 0: screen coordinates and tile addresses.
  // Scroll bit 8 cannot change a cell address mod 256, so 8-bit sums suffice.
  logic [7:0] y8, x_s, y_s, sx, sy;
  logic [9:0] fg_addr, bg_addr;
  logic       act0;
  always_comb begin
    y8      = v[7:0] - 8'd16;
    x_s     = i_FLIP ? 8'd255 - h[7:0] : h[7:0];
    y_s     = i_FLIP ? 8'd223 - y8 : y8;
    sx      = x_s + scr_reg[0];
    sy      = y_s + scr_reg[2];
    fg_addr = {y_s[7:3], x_s[7:3]};
    bg_addr = {sy[7:3], sx[7:3]};
    act0    = (h < 9'd256) && (v >= 9'd16) && (v < 9'd240);
  end

  // Stage 1: attribute bytes; stage 2: palette bytes
  logic [7:0] fg_q, bg_q, pal_rg;
  logic [3:0] pal_b;
  logic [8:0] idx;
  assign idx = (fg_q[3:0] != 4'hF) ? {1'b1, fg_q} : {1'b0, bg_q};

  always_ff @(posedge clk) begin
    if (pix_tick) begin
      fg_q   <= fg_ram[fg_addr];
      bg_q   <= bg_ram[bg_addr];
      pal_rg <= pal_ram[{idx, 1'b0}];
      pal_b  <= pal_ram[{idx, 1'b1}][7:4];
    end
  end

  pix_t              p1, p2;
  logic [STAGES:1]   vld_pipe;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1       <= '0;
      p2       <= '0;
      vld_pipe <= '0;
    end else if (pix_tick) begin
      p1       <= '{h: h, v: v, act: act0};
      p2       <= p1;
      vld_pipe <= {vld_pipe[STAGES-1:1], 1'b1};
    end
  end

  logic show, hsync, vsync;
  assign show           = vld_pipe[STAGES] & p2.act;
  assign hsync          = (p2.h >= 9'd296) && (p2.h <= 9'd327);
  assign vsync          = (p2.v >= 9'd248) && (p2.v <= 9'd251);
  assign o_CSYNC        = ~(hsync | vsync);
  assign o_VIDEO_R      = show ? pal_rg[7:4] : 4'h0;
  assign o_VIDEO_G      = show ? pal_rg[3:0] : 4'h0;
  assign o_VIDEO_B      = show ? pal_b       : 4'h0;
  assign __REF_HCOUNTER = p2.h;
  assign __REF_VCOUNTER = p2.v;

  logic unused_bits;
  assign unused_bits = ^{sx[2:0], sy[2:0], i_CPU_ADDR[12:10]};
endmodule

// File: tb/tb_psychic5_video_core.sv
// Directed bench for psychic5_video_core: enables, raster timing, CPU port,
// FG/BG/palette lookup, scroll and flip.
module tb_psychic5_video_core;
  logic        clk = 1'b0, rst = 1'b1, cen12_n = 1'b0;
  logic        pcen_n, ncen_n;
  logic [12:0] addr = '0;
  logic [7:0]  dout = '0, din;
  logic        rd_n = 1'b1, wr_n = 1'b1, flip = 1'b0;
  logic [3:0]  cs_n = 4'hF;  // [0] BG attr, [1] FG attr, [2] scroll, [3] palette
  logic        csync;
  logic [3:0]  r, g, b;
  logic [8:0]  ref_h, ref_v;
  logic [11:0] rgb;
  int          vectors = 0, errs = 0, cyc = 0, t0;

  localparam int BG = 0, FG = 1, SCR = 2, PAL = 3;

  psychic5_video_core dut (
    .i_EMU_MCLK(clk), .i_EMU_RST(rst), .i_EMU_CLK12MPCEN_n(cen12_n),
    .o_EMU_CLK6MPCEN_n(pcen_n), .o_EMU_CLK6MNCEN_n(ncen_n),
    .i_CPU_ADDR(addr), .i_CPU_DOUT(dout), .o_CPU_DIN(din),
    .i_CPU_RD_n(rd_n), .i_CPU_WR_n(wr_n),
    .i_TM_BG_ATTR_CS_n(cs_n[0]), .i_TM_FG_ATTR_CS_n(cs_n[1]),
    .i_TM_BG_SCR_CS_n(cs_n[2]), .i_TM_PALETTE_CS_n(cs_n[3]),
    .i_FLIP(flip), .o_CSYNC(csync),
    .o_VIDEO_R(r), .o_VIDEO_G(g), .o_VIDEO_B(b),
    .__REF_HCOUNTER(ref_h), .__REF_VCOUNTER(ref_v)
  );

  assign rgb = {r, g, b};
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input int sel, input logic [9:0] a, input logic [7:0] d);
    addr = {3'b0, a}; dout = d; cs_n = 4'hF; cs_n[sel] = 1'b0; wr_n = 1'b0;
    @(posedge clk); #1;
    wr_n = 1'b1; cs_n = 4'hF;
  endtask

  task automatic cpu_rd(input string tag, input int sel, input logic [9:0] a, input logic [7:0] exp);
    addr = {3'b0, a}; cs_n = 4'hF; if (sel >= 0) cs_n[sel] = 1'b0; rd_n = 1'b0;
    @(posedge clk); #1;
    chk(tag, din, exp);
    rd_n = 1'b1; cs_n = 4'hF;
  endtask

  // Advance to the pixel whose reference counters equal (h,v); bounded.
  task automatic wait_px(input string tag, input logic [8:0] h, input logic [8:0] v);
    for (int n = 0; n < 40000; n++) begin
      @(negedge clk);
      if (ref_h == h && ref_v == v) break;
    end
    chk(tag, {ref_h, ref_v}, {h, v});
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pcen", pcen_n, 1'b1);
    chk("rst_ncen", ncen_n, 1'b1);
    chk("rst_din", din, 8'hFF);
    chk("rst_rgb", rgb, 12'h000);
    chk("rst_csync", csync, 1'b1);
    chk("rst_ref", {ref_h, ref_v}, 18'h0);

    // Enables after release, first tick counts from H=0
    rst = 1'b0;
    @(negedge clk); chk("en1_p", pcen_n, 1'b0); chk("en1_n", ncen_n, 1'b1);
    @(negedge clk); chk("en2_p", pcen_n, 1'b1); chk("en2_n", ncen_n, 1'b0);
    repeat (4) @(negedge clk);
    chk("first_ref", {ref_h, ref_v}, {9'd1, 9'd0});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("en_alt", pcen_n ^ ncen_n, 1'b1);
    end

    // CPU write/readback at top address, unselected read, double-select write
    cpu_wr(BG, 10'h3FF, 8'h5A);  cpu_rd("rd_bg", BG, 10'h3FF, 8'h5A);
    cpu_wr(FG, 10'h3FF, 8'hC3);  cpu_rd("rd_fg", FG, 10'h3FF, 8'hC3);
    cpu_wr(PAL, 10'h3FF, 8'h96); cpu_rd("rd_pal", PAL, 10'h3FF, 8'h96);
    cpu_wr(SCR, 10'h003, 8'h7B); cpu_rd("rd_scr", SCR, 10'h003, 8'h7B);
    cpu_rd("rd_nocs", -1, 10'h3FF, 8'hFF);
    addr = 13'h3FF; dout = 8'h11; cs_n = 4'b1100; wr_n = 1'b0;
    @(posedge clk); #1; wr_n = 1'b1; cs_n = 4'hF;
    cpu_rd("dual_cs", FG, 10'h3FF, 8'hC3);
    @(posedge clk); #1; chk("rd_idle", din, 8'hFF);

    // Scene: background colour 0 everywhere, FG cell 0 uses palette 0x101
    cpu_wr(SCR, 10'h003, 8'h00);
    for (int i = 0; i < 1024; i++) begin
      cpu_wr(FG, 10'(i), 8'h0F);
      cpu_wr(BG, 10'(i), 8'h00);
    end
    cpu_wr(PAL, 10'h000, 8'hA5); cpu_wr(PAL, 10'h001, 8'h3C);
    cpu_wr(PAL, 10'h202, 8'hF0); cpu_wr(PAL, 10'h203, 8'h00);
    cpu_wr(FG, 10'h000, 8'h01);

    wait_px("w0_16", 9'd0, 9'd16);     chk("fg_h0", rgb, 12'hF00);
    wait_px("w7_16", 9'd7, 9'd16);     chk("fg_h7", rgb, 12'hF00);
    wait_px("w8_16", 9'd8, 9'd16);     chk("bg_h8", rgb, 12'hA53);
    wait_px("w100_16", 9'd100, 9'd16); chk("bg_h100", rgb, 12'hA53);
    wait_px("w295", 9'd295, 9'd16);    chk("cs_295", csync, 1'b1);
    wait_px("w296", 9'd296, 9'd16);    chk("cs_296", csync, 1'b0);
    wait_px("w300", 9'd300, 9'd16);    chk("cs_300", csync, 1'b0); chk("rgb_300", rgb, 12'h000);
    wait_px("w327", 9'd327, 9'd16);    chk("cs_327", csync, 1'b0);
    wait_px("w328", 9'd328, 9'd16);    chk("cs_328", csync, 1'b1);
    wait_px("w7_23", 9'd7, 9'd23);     chk("fg_v23", rgb, 12'hF00);
    wait_px("w0_24", 9'd0, 9'd24);     chk("bg_v24", rgb, 12'hA53);
    wait_px("w0_30", 9'd0, 9'd30);     t0 = cyc;
    wait_px("w0_31", 9'd0, 9'd31);     chk("h_period", cyc - t0, 768);

    // Scroll: SCRY=232 makes V 40..47 show BG row 0, SCRX=8 shifts cell 1 to H 0..7
    cpu_wr(FG, 10'h000, 8'h0F);
    cpu_wr(BG, 10'h001, 8'h10);
    cpu_wr(PAL, 10'h020, 8'h7E); cpu_wr(PAL, 10'h021, 8'h90);
    cpu_wr(SCR, 10'h000, 8'h08); cpu_wr(SCR, 10'h002, 8'hE8);
    wait_px("w0_40", 9'd0, 9'd40);     chk("scr_h0", rgb, 12'h7E9);
    wait_px("w7_40", 9'd7, 9'd40);     chk("scr_h7", rgb, 12'h7E9);
    wait_px("w8_40", 9'd8, 9'd40);     chk("scr_h8", rgb, 12'hA53);

    // Flip: FG cell (row 22, col 31) lands at H 0..7, V 56..63
    cpu_wr(SCR, 10'h000, 8'h00); cpu_wr(SCR, 10'h002, 8'h00);
    cpu_wr(FG, 10'd735, 8'h01);
    flip = 1'b1;
    wait_px("w0_56", 9'd0, 9'd56);     chk("flip_h0", rgb, 12'hF00);
    wait_px("w8_56", 9'd8, 9'd56);     chk("flip_h8", rgb, 12'hA53);
    wait_px("w7_63", 9'd7, 9'd63);     chk("flip_v63", rgb, 12'hF00);
    wait_px("w0_64", 9'd0, 9'd64);     chk("flip_v64", rgb, 12'hA53);

    // Mid-frame reset restarts the raster
    rst = 1'b1; #1;
    chk("mrst_ref", {ref_h, ref_v}, 18'h0);
    chk("mrst_rgb", rgb, 12'h000);
    chk("mrst_pcen", pcen_n, 1'b1);
    @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("mrst_first", {ref_h, ref_v}, {9'd1, 9'd0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
